// File: rtl/multiplier_seq.sv
`default_nettype none
// ============================================================================
// Module   : multiplier_seq
// Purpose  : Sequential shift-add multiplier for MUL (a*b) and MLA (a*b+c).
//            Optional early termination: define MUL_EARLY_TERM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module multiplier_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] op_c,
    input  logic             acc_en,
    input  logic [3:0]       wa_in,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             we3,
    output logic [3:0]       wa3,
    output logic             flag_n,
    output logic             flag_z
);

    localparam int               CNT_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_result;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_wa;

    logic [WIDTH-1:0] w_addend;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_last;

    assign w_addend   = r_mplier[0] ? r_mcand : '0;
    assign w_acc_next = r_acc + w_addend;

`ifdef MUL_EARLY_TERM_EN
    // Once the multiplier has shifted out to zero nothing more can be added.
    assign w_last = (r_cnt == C_CNT_LAST) || (r_mplier == '0);
`else
    assign w_last = (r_cnt == C_CNT_LAST);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_wa     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand  <= op_a;
                        r_mplier <= op_b;
                        r_acc    <= acc_en ? op_c : '0;
                        r_wa     <= wa_in;
                        r_cnt    <= '0;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    if (w_last) begin
                        r_result <= w_acc_next;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = (r_state != S_IDLE);
    // Gated with reset_n so the front end is released while reset is held.
    assign stall  = busy | (start & (r_state == S_IDLE) & reset_n);
    assign done   = (r_state == S_DONE);
    assign we3    = done;
    assign result = r_result;
    assign wa3    = r_wa;
    assign flag_n = r_result[WIDTH-1];
    assign flag_z = (r_result == '0);

endmodule
`default_nettype wire

// File: tb/tb_multiplier_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_multiplier_seq
// Purpose  : Scoreboard bench for multiplier_seq with a plain-arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multiplier_seq;

    localparam int WIDTH = 32;
`ifdef MUL_EARLY_TERM_EN
    localparam bit ET_EN = 1'b1;
`else
    localparam bit ET_EN = 1'b0;
`endif

    logic             clk     = 1'b0;
    logic             reset_n = 1'b0;
    logic             start   = 1'b1;
    logic             acc_en  = 1'b0;
    logic [WIDTH-1:0] op_a    = '0;
    logic [WIDTH-1:0] op_b    = '0;
    logic [WIDTH-1:0] op_c    = '0;
    logic [3:0]       wa_in   = '0;
    logic             busy, stall, done, we3, flag_n, flag_z;
    logic [WIDTH-1:0] result;
    logic [3:0]       wa3;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic [3:0]       wa;
        int               edge_no;
    } exp_t;

    exp_t             sb[$];
    exp_t             mon_e;
    int               n_chk    = 0;
    int               n_fail   = 0;
    int               edge_cnt = 0;
    logic [WIDTH-1:0] last_res = '0;

    multiplier_seq #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .op_a   (op_a),
        .op_b   (op_b),
        .op_c   (op_c),
        .acc_en (acc_en),
        .wa_in  (wa_in),
        .busy   (busy),
        .stall  (stall),
        .done   (done),
        .result (result),
        .we3    (we3),
        .wa3    (wa3),
        .flag_n (flag_n),
        .flag_z (flag_z)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt = edge_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Truncated product (plus addend) from plain 64-bit arithmetic.
    function automatic logic [WIDTH-1:0] ref_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                 input logic [WIDTH-1:0] c, input logic acc);
        logic [63:0] p;
        p = 64'(a) * 64'(b) + (acc ? 64'(c) : 64'd0);
        return p[WIDTH-1:0];
    endfunction

    // Edges from the accepting edge to the edge that enters DONE.
    function automatic int ref_lat(input logic [WIDTH-1:0] b);
        int msb;
        if (!ET_EN) return WIDTH;
        msb = -1;
        for (int i = 0; i < WIDTH; i++) if (b[i]) msb = i;
        return (msb + 2 < WIDTH) ? msb + 2 : WIDTH;
    endfunction

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while (busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("idle_wait", busy, 0);
    endtask

    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] c, input logic acc, input logic [3:0] wa);
        exp_t e;
        wait_idle();
        op_a = a; op_b = b; op_c = c; acc_en = acc; wa_in = wa; start = 1'b1;
        #1;
        chk("stall_on_start", stall, 1);
        e.res     = ref_mul(a, b, c, acc);
        e.wa      = wa;
        e.edge_no = edge_cnt + 1 + ref_lat(b);
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        op_a = $urandom; op_b = $urandom; op_c = $urandom;
        acc_en = 1'($urandom_range(0, 1)); wa_in = 4'($urandom);
    endtask

    // Monitor: compares every DONE cycle against the scoreboard head.
    initial forever begin
        @(negedge clk);
        if (reset_n) begin
            if (done) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL spurious_done: done=1 with no outstanding request at t=%0t", $time);
                end else begin
                    mon_e = sb.pop_front();
                    chk("result", result, mon_e.res);
                    chk("wa3", wa3, mon_e.wa);
                    chk("we3_in_done", we3, 1);
                    chk("flag_n", flag_n, mon_e.res[WIDTH-1]);
                    chk("flag_z", flag_z, (mon_e.res == '0));
                    chk("done_edge", edge_cnt, mon_e.edge_no);
                    last_res = mon_e.res;
                end
            end else begin
                chk("we3_idle", we3, 0);
                chk("result_hold", result, last_res);
                if (sb.size() > 0 && edge_cnt > sb[0].edge_no) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL done_missing: no done by edge %0d, expected at edge %0d", edge_cnt, sb[0].edge_no);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   k_a;
        int   k_b;
        int   t;

        // Reset state, with start asserted to confirm stall is held low.
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_stall", stall, 0);
        chk("rst_done", done, 0);
        chk("rst_we3", we3, 0);
        chk("rst_result", result, 0);
        chk("rst_wa3", wa3, 0);
        start = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        // Directed cases
        issue(32'd7, 32'd6, 32'hDEAD_BEEF, 1'b0, 4'd3);
        issue(32'hFFFF_FFFF, 32'd2, 32'd5, 1'b1, 4'd9);
        issue(32'd0, 32'h1234_5678, 32'd0, 1'b0, 4'd1);
        issue(32'h8000_0000, 32'd1, 32'd0, 1'b0, 4'd2);
        issue(32'h0BAD_CAFE, 32'd1, 32'd77, 1'b0, 4'd4);
        issue(32'h0BAD_CAFE, 32'd0, 32'h1357_9BDF, 1'b1, 4'd5);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'd15);

        // Randomized operands, with varied multiplier magnitudes
        for (int i = 0; i < 40; i++)
            issue($urandom, $urandom >> $urandom_range(0, 31), $urandom,
                  1'($urandom_range(0, 1)), 4'($urandom));

        // Start held high through RUN with different operands
        wait_idle();
        op_a = 32'd11; op_b = 32'd13; op_c = 32'd100; acc_en = 1'b1; wa_in = 4'd6; start = 1'b1;
        k_a       = edge_cnt + 1;
        e.res     = ref_mul(32'd11, 32'd13, 32'd100, 1'b1);
        e.wa      = 4'd6;
        e.edge_no = k_a + ref_lat(32'd13);
        sb.push_back(e);
        @(negedge clk);
        op_a = 32'h0001_0001; op_b = 32'h0000_0300; op_c = 32'd9; acc_en = 1'b0; wa_in = 4'd12;
        k_b       = k_a + ref_lat(32'd13) + 2;
        e.res     = ref_mul(32'h0001_0001, 32'h0000_0300, 32'd9, 1'b0);
        e.wa      = 4'd12;
        e.edge_no = k_b + ref_lat(32'h0000_0300);
        sb.push_back(e);
        while (edge_cnt < k_b) @(negedge clk);
        start = 1'b0;
        op_a = $urandom; op_b = $urandom; op_c = $urandom;

        // Reset in RUN cycle 10 aborts without a write
        issue(32'h1234_5678, 32'hFFFF_FFFF, 32'd0, 1'b0, 4'd7);
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        start   = 1'b1;
        #1;
        void'(sb.pop_back());
        last_res = '0;
        chk("abort_busy", busy, 0);
        chk("abort_result", result, 0);
        chk("abort_done", done, 0);
        chk("abort_we3", we3, 0);
        chk("abort_stall", stall, 0);
        chk("abort_wa3", wa3, 0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        // Operation resumes normally after the abort
        issue(32'd1000, 32'd1000, 32'd1, 1'b1, 4'd8);
        issue($urandom, $urandom, $urandom, 1'b1, 4'd10);

        t = 0;
        while (sb.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_empty", sb.size(), 0);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
